div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring integer divider for the RV64 M extension.
- Sits in the execute stage beside the ALU and is fed by the same decode signals (func3, W-variant select) that drive the ALU control decoding.
- Handles DIV/DIVU/REM/REMU and their W variants with a start/busy/done handshake.
- The hazard unit stalls the pipeline while o_busy is high.

Parameters:
- XLEN, 64, operand and result width; W variants use bits [31:0].

Ports:
- i_clk  in  1  clock, rising edge.
- i_arst  in  1  reset, asynchronous, active-high.
- i_start  in  1  request a division; sampled only in IDLE.
- i_flush  in  1  abort any in-flight operation.
- i_func3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; only bits [1:0] are decoded.
- i_word  in  1  1 selects a W variant (DIVW/DIVUW/REMW/REMUW).
- i_src_a  in  XLEN  dividend.
- i_src_b  in  XLEN  divisor.
- o_busy  out  1  high in CALC and DONE.
- o_done  out  1  single-cycle pulse; result valid.
- o_result  out  XLEN  quotient or remainder; held until the next accepted start.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: FSM to IDLE; o_busy=0, o_done=0, o_result=0; counter and working registers cleared. Reset mid-operation discards the operation with no o_done.
- FSM states: IDLE, CALC, DONE.
- IDLE -> DONE: i_start=1, i_flush=0, and the operation is a special case.
- IDLE -> CALC: i_start=1, i_flush=0, normal case.
- CALC -> DONE: when the iteration counter reaches N-1, where N=64 (i_word=0) or 32 (i_word=1).
- DONE -> IDLE: always, after one cycle.
- Operand capture at the start edge:
  - Signed ops (func3[0]=0): magnitudes of the operands; negate-quotient flag = sign(a) XOR sign(b); negate-remainder flag = sign(a).
  - W variants: take src[31:0], sign-extend (signed) or zero-extend (unsigned) before taking magnitudes.
- Iteration, once per CALC cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor from rem.
  - If non-negative: commit the difference and set the quo LSB.
- Finalisation, registered into o_result on entry to DONE:
  - Apply the negation flags.
  - Select quo (func3[1]=0) or rem (func3[1]=1).
  - W variants: sign-extend result bit 31 to XLEN for all four ops, including DIVUW/REMUW.
- Special cases, decided at the start edge with no iterations:
  - Divisor zero: quotient = all ones; remainder = dividend (after W truncation/extension).
  - Signed overflow (dividend = most-negative, divisor = -1, at the 64- or 32-bit width): quotient = dividend, remainder = 0.
- Latency, with start accepted at edge t:
  - Special case: o_done high during cycle t+1.
  - Normal case: o_done high during cycle t+N+1, i.e. t+65 (64-bit) or t+33 (W).
- o_busy goes high in cycle t+1 and low in the cycle after o_done.
- i_start while o_busy=1 is ignored; no queueing.
- i_flush:
  - In any state, FSM returns to IDLE at the next edge; o_done stays 0; o_result is unchanged.
  - i_flush and i_start in the same cycle: flush wins and the start is dropped.
  - i_flush in DONE: the pulse in that cycle already occurred and is not retracted.
- Back-to-back: a new i_start is accepted in the IDLE cycle after DONE; minimum spacing is 2 cycles.

Decomposition:
- Shared package (M-extension package):
  - func3 encodings: DIV, DIVU, REM, REMU.
  - FSM state enum: IDLE, CALC, DONE.
  - XLEN constant.
  - Iteration-count constants: 64 and 32.
- Single module; no sub-module. The one-bit restoring step is inline combinational logic.

Test Plan:
- DIV a=100, b=7, word=0 -> o_done at t+65, o_result=14; REM same operands -> 2.
- REM a=-7, b=2 -> -1 (0xFFFF_FFFF_FFFF_FFFF); DIV a=-7, b=2 -> -3.
- DIVU a=5, b=0 -> o_done at t+1, o_result=0xFFFF_FFFF_FFFF_FFFF; REMU same operands -> 5.
- DIV a=0x8000_0000_0000_0000, b=-1 -> o_done at t+1, o_result=0x8000_0000_0000_0000; REMW a=0x8000_0000, b=-1 -> 0.
- DIVUW a=0xFFFF_FFFF, b=1 -> o_done at t+33, o_result=0xFFFF_FFFF_FFFF_FFFF (sign-extended).
- Start DIV 100/7, assert i_flush at t+10 together with a second i_start -> no o_done ever, o_busy=0 at t+11. Start again, and pulse i_start during CALC -> exactly one o_done, for the first request.

Source files
------------

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared RV64 M-extension divider constants and types
package div_unit_pkg;
   localparam int XLEN_RV64 = 64;
   localparam int ITER_D = 64;
   localparam int ITER_W = 32;
   localparam logic [2:0] F3_DIV = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and W variants
module div_unit
   import div_unit_pkg::*;
#(
   parameter int XLEN = XLEN_RV64
) (
   input  logic            i_clk,
   input  logic            i_arst,
   input  logic            i_start,
   input  logic            i_flush,
   input  logic [2:0]      i_func3,
   input  logic            i_word,
   input  logic [XLEN-1:0] i_src_a,
   input  logic [XLEN-1:0] i_src_b,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);
   state_t state, state_nx;
   logic [XLEN-1:0] rem, quo, dvs, a_ext, b_ext, a_mag, b_mag, spc_res;
   logic [XLEN-1:0] rem_lo, trial, rem_nx, quo_nx, q_fin, r_fin, fin_res;
   logic [5:0] cnt;
   logic neg_q, neg_r, word, sel_rem, sgn, div0, ovf, special, accept, last, ge;
   logic unused_f3;

   assign unused_f3 = i_func3[2];

   function automatic logic [XLEN-1:0] wsext(input logic [XLEN-1:0] v, input logic w);
      return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   // operand extension, magnitudes and special-case detection at the start edge
   always_comb begin
      sgn = ~i_func3[0];
      a_ext = i_word ? {{(XLEN-32){sgn & i_src_a[31]}}, i_src_a[31:0]} : i_src_a;
      b_ext = i_word ? {{(XLEN-32){sgn & i_src_b[31]}}, i_src_b[31:0]} : i_src_b;
      a_mag = (sgn & a_ext[XLEN-1]) ? -a_ext : a_ext;
      b_mag = (sgn & b_ext[XLEN-1]) ? -b_ext : b_ext;
      div0 = b_ext == '0;
      ovf = sgn & (&b_ext) & (a_ext == (i_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}}));
      special = div0 | ovf;
      spc_res = wsext(i_func3[1] ? (div0 ? a_ext : '0) : (div0 ? '1 : a_ext), i_word);
      accept = i_start & ~i_flush & (state == IDLE);
   end

   // one restoring step; a carried-out MSB means the shifted remainder already exceeds the divisor
   always_comb begin
      rem_lo = {rem[XLEN-2:0], quo[XLEN-1]};
      trial = rem_lo - dvs;
      ge = rem[XLEN-1] | (rem_lo >= dvs);
      rem_nx = ge ? trial : rem_lo;
      quo_nx = {quo[XLEN-2:0], ge};
      q_fin = neg_q ? -quo_nx : quo_nx;
      r_fin = neg_r ? -rem_nx : rem_nx;
      fin_res = wsext(sel_rem ? r_fin : q_fin, word);
      last = cnt == (word ? 6'(ITER_W-1) : 6'(ITER_D-1));
   end

   // state register
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) state <= IDLE;
      else state <= state_nx;
   end

   // next-state logic; flush always wins
   always_comb begin
      state_nx = i_flush ? IDLE :
                 (state == IDLE) ? (i_start ? (special ? DONE : CALC) : IDLE) :
                 (state == CALC) ? (last ? DONE : CALC) : IDLE;
   end

   // handshake outputs
   always_comb begin
      o_busy = state != IDLE;
      o_done = state == DONE;
   end

   // operand capture, iteration and result registration
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         rem <= '0;
         quo <= '0;
         dvs <= '0;
         cnt <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         word <= 1'b0;
         sel_rem <= 1'b0;
         o_result <= '0;
      end else if (accept) begin
         rem <= '0;
         quo <= i_word ? a_mag << 32 : a_mag;
         dvs <= b_mag;
         cnt <= '0;
         neg_q <= sgn & (a_ext[XLEN-1] ^ b_ext[XLEN-1]);
         neg_r <= sgn & a_ext[XLEN-1];
         word <= i_word;
         sel_rem <= i_func3[1];
         if (special) o_result <= spc_res;
      end else if (state == CALC && !i_flush) begin
         rem <= rem_nx;
         quo <= quo_nx;
         cnt <= cnt + 6'd1;
         if (last) o_result <= fin_res;
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector and corner-sequence bench for div_unit
module tb_div_unit;
   import div_unit_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_arst = 1'b1;
   logic        i_start = 1'b0;
   logic        i_flush = 1'b0;
   logic [2:0]  i_func3 = F3_DIV;
   logic        i_word = 1'b0;
   logic [63:0] i_src_a = '0;
   logic [63:0] i_src_b = '0;
   logic        o_busy, o_done;
   logic [63:0] o_result;
   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;

   typedef struct {
      logic [2:0]  f3;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      int          lat;
      string       name;
   } vec_t;

   vec_t v[16];

   div_unit dut (
      .i_clk(i_clk), .i_arst(i_arst), .i_start(i_start), .i_flush(i_flush),
      .i_func3(i_func3), .i_word(i_word), .i_src_a(i_src_a), .i_src_b(i_src_b),
      .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) if (o_done) done_cnt++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat);
      i_func3 = f3;
      i_word = w;
      i_src_a = a;
      i_src_b = b;
      i_start = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      lat = -1;
      res = 'x;
      for (int n = 1; n <= 100 && lat < 0; n++) begin
         @(negedge i_clk);
         if (o_done) begin
            lat = n;
            res = o_result;
         end
      end
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      logic [63:0] res;
      int lat, d0;
      v[0]  = '{F3_DIV,  1'b0, 64'd100, 64'd7, 64'd14, 65, "div_100_7"};
      v[1]  = '{F3_REM,  1'b0, 64'd100, 64'd7, 64'd2, 65, "rem_100_7"};
      v[2]  = '{F3_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "rem_m7_2"};
      v[3]  = '{F3_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_m7_2"};
      v[4]  = '{F3_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu_by0"};
      v[5]  = '{F3_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1, "remu_by0"};
      v[6]  = '{F3_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, "div_ovf"};
      v[7]  = '{F3_REM,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, "remw_ovf"};
      v[8]  = '{F3_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, "divuw_sext"};
      v[9]  = '{F3_DIV,  1'b1, 64'h1234_5678_FFFF_FFEC, 64'hABCD_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 33, "divw_m20_3"};
      v[10] = '{F3_REM,  1'b1, 64'h1234_5678_FFFF_FFEC, 64'hABCD_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFE, 33, "remw_m20_3"};
      v[11] = '{F3_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 65, "divu_max_2"};
      v[12] = '{F3_REMU, 1'b0, 64'h0000_0000_0000_0123, 64'h10, 64'd3, 65, "remu_123_10"};
      v[13] = '{F3_REMU, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1, "remuw_by0"};
      v[14] = '{F3_DIV,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_7_m2"};
      v[15] = '{F3_REM,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, "rem_7_m2"};

      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_busy", {63'b0, o_busy}, 64'd0);
      chk("reset_done", {63'b0, o_done}, 64'd0);
      chk("reset_result", o_result, 64'd0);
      i_arst = 1'b0;
      @(posedge i_clk);
      #1;

      for (int i = 0; i < 16; i++) begin
         run_op(v[i].f3, v[i].w, v[i].a, v[i].b, res, lat);
         chk({v[i].name, "_lat"}, 64'(lat), 64'(v[i].lat));
         chk({v[i].name, "_res"}, res, v[i].res);
         chk({v[i].name, "_idle"}, {63'b0, o_busy}, 64'd0);
      end

      d0 = done_cnt;
      i_func3 = F3_DIV; i_word = 1'b0; i_src_a = 64'd100; i_src_b = 64'd7; i_start = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      repeat (9) @(posedge i_clk);
      #1 begin i_flush = 1'b1; i_start = 1'b1; end
      @(posedge i_clk);
      #1 begin i_flush = 1'b0; i_start = 1'b0; end
      @(negedge i_clk);
      chk("flush_busy", {63'b0, o_busy}, 64'd0);
      repeat (80) @(posedge i_clk);
      #1;
      chk("flush_no_done", 64'(done_cnt - d0), 64'd0);
      chk("flush_result_held", o_result, 64'd1);

      d0 = done_cnt;
      i_func3 = F3_DIV; i_src_a = 64'd100; i_src_b = 64'd7; i_start = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      repeat (4) @(posedge i_clk);
      #1 begin i_func3 = F3_DIVU; i_src_a = 64'd5; i_src_b = 64'd0; i_start = 1'b1; end
      @(posedge i_clk);
      #1 i_start = 1'b0;
      repeat (100) @(posedge i_clk);
      #1;
      chk("busy_start_one_done", 64'(done_cnt - d0), 64'd1);
      chk("busy_start_result", o_result, 64'd14);

      d0 = done_cnt;
      i_func3 = F3_DIV; i_src_a = 64'd100; i_src_b = 64'd7; i_start = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      repeat (20) @(posedge i_clk);
      #2 i_arst = 1'b1;
      #1;
      chk("arst_busy", {63'b0, o_busy}, 64'd0);
      chk("arst_result", o_result, 64'd0);
      @(posedge i_clk);
      #1 i_arst = 1'b0;
      repeat (80) @(posedge i_clk);
      #1;
      chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
      chk("arst_result_after", o_result, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
